// File: rtl/obstacle_spawner.sv
// obstacle_spawner: scrolls, retires and LFSR-spawns 10 obstacles once per vsync frame; OBSTACLE_LANE_GUARD_EN cancels spawns into a lane still occupied near the spawn edge
module obstacle_spawner #(
  parameter int SCREEN_WIDTH = 1024,
  parameter int SPAWN_MIN = 30,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic system_clock_in,
  input logic reset_in,
  input logic vsync,
  input logic running,
  input logic clear,
  input logic [3:0] speed,
  output logic [9:0][13:0] obstacles,
  output logic [3:0] active_count,
  output logic spawn_pulse
);
`ifdef OBSTACLE_LANE_GUARD_EN
  localparam int OBSTACLE_WIDTH = 32;
`endif
  logic [15:0] lfsr;
  logic vsync_q, tick, step, found, blocked, spawn;
  logic [6:0] cd;
  logic [9:0][13:0] nxt;
  logic [3:0] slot, cnt;
  logic [1:0] lane;
  assign tick = vsync_q & ~vsync;
  assign step = tick & running;
  assign lane = lfsr[1:0] == 2'd3 ? 2'd1 : lfsr[1:0];
  // slot choice and guard look only at pre-tick state, so same-tick retirements are not reused
  always_comb begin
    slot = '0;
    found = 1'b0;
    blocked = 1'b0;
    cnt = '0;
    for (int i = 9; i >= 0; i--)
      if (!obstacles[i][13]) begin
        slot = 4'(i);
        found = 1'b1;
      end
`ifdef OBSTACLE_LANE_GUARD_EN
    for (int i = 0; i < 10; i++)
      if (obstacles[i][13] && obstacles[i][12:11] == lane && obstacles[i][10:0] > 11'(SCREEN_WIDTH - 2 * OBSTACLE_WIDTH))
        blocked = 1'b1;
`endif
    for (int i = 0; i < 10; i++) begin
      nxt[i] = obstacles[i];
      if (obstacles[i][13]) begin
        if (obstacles[i][10:0] < 11'(speed)) nxt[i][13] = 1'b0;
        else nxt[i][10:0] = obstacles[i][10:0] - 11'(speed);
      end
    end
    spawn = cd == '0 && found && !blocked;
    if (spawn) nxt[slot] = {1'b1, lane, 11'(SCREEN_WIDTH)};
    for (int i = 0; i < 10; i++) cnt = cnt + 4'(nxt[i][13]);
  end
  always_ff @(posedge system_clock_in) begin
    if (reset_in) begin
      lfsr <= LFSR_SEED;
      vsync_q <= 1'b1;
      cd <= 7'(SPAWN_MIN);
      obstacles <= '0;
      active_count <= '0;
      spawn_pulse <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      vsync_q <= vsync;
      spawn_pulse <= 1'b0;
      if (clear) begin
        obstacles <= '0;
        active_count <= '0;
        cd <= 7'(SPAWN_MIN);
      end else if (step) begin
        obstacles <= nxt;
        active_count <= cnt;
        spawn_pulse <= spawn;
        cd <= cd == '0 ? 7'(SPAWN_MIN) + 7'(lfsr[5:0]) : cd - 7'd1;
      end
    end
  end
endmodule
